// File: rtl/cpu_pkg.sv
// Shared types for the CPU control path: stage encoding, sequencer states, flag bundle.
package cpu_pkg;

  localparam int DEF_PC_W = 10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WB    = 2'b10
  } stage_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } seq_state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
    logic zero;
  } flags_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for call/ret. The pointer counts valid entries, so
// full and empty come straight from its value.
module return_stack #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PC_W-1:0]  mem_r [STACK_DEPTH];
  logic [PTR_W-1:0] ptr_r;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] top_idx_s;

  assign wr_idx_s  = IDX_W'(ptr_r);
  assign top_idx_s = IDX_W'(ptr_r - PTR_ONE);
  assign top       = mem_r[top_idx_s];
  assign full      = (ptr_r == FULL_PTR);
  assign empty     = (ptr_r == {PTR_W{1'b0}});

  // Storage and pointer; pop takes precedence if both are requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_r[i] <= {PC_W{1'b0}};
      end
    end else if (pop && !empty) begin
      ptr_r <= ptr_r - PTR_ONE;
    end else if (push && !full) begin
      mem_r[wr_idx_s] <= din;
      ptr_r           <= ptr_r + PTR_ONE;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Three-stage instruction sequencer: owns stage count, pc, compare flags and
// the call/return stack consumed by the control decoder.
module stage_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W        = cpu_pkg::DEF_PC_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] target,
  input  logic            alu_eq,
  input  logic            alu_gt,
  input  logic            alu_lt,
  input  logic            alu_zero,
  input  logic            flag_we,
  output logic [1:0]      stage,
  output logic [PC_W-1:0] pc,
  output logic            equalQ,
  output logic            gtQ,
  output logic            ltQ,
  output logic            zeroQ,
  output logic            running,
  output logic            done,
  output logic            stack_err
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  seq_state_t      state_r, state_nxt_s;
  stage_t          stage_r, stage_nxt_s;
  logic [PC_W-1:0] pc_r, pc_nxt_s, pc_inc_s;
  flags_t          flags_r, flags_nxt_s;
  logic            err_r, err_nxt_s;
  logic            running_r, done_r;
  logic            push_s, pop_s;
  logic [PC_W-1:0] stk_top_s;
  logic            stk_full_s, stk_empty_s;

  assign pc_inc_s  = pc_r + PC_ONE;
  assign stage     = stage_r;
  assign pc        = pc_r;
  assign equalQ    = flags_r.eq;
  assign gtQ       = flags_r.gt;
  assign ltQ       = flags_r.lt;
  assign zeroQ     = flags_r.zero;
  assign running   = running_r;
  assign done      = done_r;
  assign stack_err = err_r;

  return_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_inc_s),
    .top   (stk_top_s),
    .full  (stk_full_s),
    .empty (stk_empty_s)
  );

  // Next-state, stage advance, flag capture and pc redirect.
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    pc_nxt_s    = pc_r;
    flags_nxt_s = flags_r;
    err_nxt_s   = err_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      IDLE, HALT: begin
        stage_nxt_s = ST_FETCH;
        if (start) begin
          state_nxt_s = RUN;
          pc_nxt_s    = {PC_W{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (!stall) begin
          case (stage_r)
            ST_FETCH: stage_nxt_s = ST_EXEC;
            ST_EXEC: begin
              stage_nxt_s = ST_WB;
              if (flag_we) begin
                flags_nxt_s.eq   = alu_eq;
                flags_nxt_s.gt   = alu_gt;
                flags_nxt_s.lt   = alu_lt;
                flags_nxt_s.zero = alu_zero;
              end else begin
                flags_nxt_s = flags_r;
              end
            end
            ST_WB: begin
              stage_nxt_s = ST_FETCH;
              if (halt_req) begin
                state_nxt_s = HALT;
              end else begin
                state_nxt_s = RUN;
              end
              // Redirect priority: ret, then call, then jump, else sequential.
              if (ret) begin
                if (!stk_empty_s) begin
                  pc_nxt_s = stk_top_s;
                  pop_s    = 1'b1;
                end else begin
                  pc_nxt_s  = pc_inc_s;
                  err_nxt_s = 1'b1;
                end
              end else if (call) begin
                pc_nxt_s = target;
                if (!stk_full_s) begin
                  push_s = 1'b1;
                end else begin
                  err_nxt_s = 1'b1;
                end
              end else if (jump) begin
                pc_nxt_s = target;
              end else begin
                pc_nxt_s = pc_inc_s;
              end
            end
            default: stage_nxt_s = ST_FETCH;
          endcase
        end else begin
          stage_nxt_s = stage_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        stage_nxt_s = ST_FETCH;
        pc_nxt_s    = {PC_W{1'b0}};
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_r   <= ST_FETCH;
      pc_r      <= {PC_W{1'b0}};
      flags_r   <= '{eq: 1'b0, gt: 1'b0, lt: 1'b0, zero: 1'b0};
      err_r     <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      stage_r   <= stage_nxt_s;
      pc_r      <= pc_nxt_s;
      flags_r   <= flags_nxt_s;
      err_r     <= err_nxt_s;
      running_r <= (state_nxt_s == RUN);
      done_r    <= (state_nxt_s == HALT);
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: inputs change and outputs are checked on
// the falling edge, with hand-computed expectations.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stall, halt_req, jump, call, ret;
  logic [9:0] target;
  logic       alu_eq, alu_gt, alu_lt, alu_zero, flag_we;
  logic [1:0] stage;
  logic [9:0] pc;
  logic       equalQ, gtQ, ltQ, zeroQ, running, done, stack_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.PC_W(10), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .jump(jump), .call(call), .ret(ret), .target(target),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt), .alu_zero(alu_zero),
    .flag_we(flag_we), .stage(stage), .pc(pc), .equalQ(equalQ), .gtQ(gtQ),
    .ltQ(ltQ), .zeroQ(zeroQ), .running(running), .done(done), .stack_err(stack_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // From stage 00: run to stage 10, present redirect controls for one edge.
  task automatic instr(input logic j, input logic c, input logic r, input logic [9:0] tgt);
    step();
    step();
    jump = j; call = c; ret = r; target = tgt;
    step();
    jump = 1'b0; call = 1'b0; ret = 1'b0; target = 10'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".stage"}, 32'(stage), 32'd0);
    chk({tag, ".pc"}, 32'(pc), 32'd0);
    chk({tag, ".flags"}, 32'({equalQ, gtQ, ltQ, zeroQ}), 32'd0);
    chk({tag, ".running"}, 32'(running), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".err"}, 32'(stack_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_stage [6];
    logic [9:0] exp_pc    [6];
    logic [9:0] ret_pc    [4];
    exp_stage = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    exp_pc    = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd1, 10'd2};
    ret_pc    = '{10'd301, 10'd201, 10'd101, 10'd7};

    reset = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    jump = 1'b0; call = 1'b0; ret = 1'b0; target = 10'd0;
    alu_eq = 1'b0; alu_gt = 1'b0; alu_lt = 1'b0; alu_zero = 1'b0; flag_we = 1'b0;
    step(); step();
    chk_reset_vals("reset");
    reset = 1'b0;
    step();
    chk("idle.running", 32'(running), 32'd0);

    // Test 1: start and free-running stage sequence
    start = 1'b1; step(); start = 1'b0;
    chk("start.running", 32'(running), 32'd1);
    chk("start.stage", 32'(stage), 32'd0);
    chk("start.pc", 32'(pc), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("seq%0d.stage", i), 32'(stage), 32'(exp_stage[i]));
      chk($sformatf("seq%0d.pc", i), 32'(pc), 32'(exp_pc[i]));
    end

    // Test 2: flags load only from stage 01
    flag_we = 1'b1; alu_lt = 1'b1; step();
    chk("flag.s0_lt", 32'(ltQ), 32'd0);
    alu_lt = 1'b0; alu_eq = 1'b1; step();
    chk("flag.eq", 32'(equalQ), 32'd1);
    chk("flag.lt", 32'(ltQ), 32'd0);
    flag_we = 1'b0; alu_eq = 1'b0; step();
    chk("flag.hold_eq", 32'(equalQ), 32'd1);
    chk("flag.pc3", 32'(pc), 32'd3);

    // Test 3: call then ret
    instr(1'b0, 1'b0, 1'b0, 10'd0);
    instr(1'b0, 1'b0, 1'b0, 10'd0);
    chk("call.pc5", 32'(pc), 32'd5);
    instr(1'b0, 1'b1, 1'b0, 10'd40);
    chk("call.pc40", 32'(pc), 32'd40);
    instr(1'b0, 1'b0, 1'b0, 10'd0);
    chk("call.pc41", 32'(pc), 32'd41);
    instr(1'b1, 1'b0, 1'b1, 10'd99);
    chk("ret.pc6", 32'(pc), 32'd6);
    chk("ret.err", 32'(stack_err), 32'd0);

    // Test 4: overflow on the fifth nested call, LIFO unwind, then underflow
    for (int i = 1; i <= 4; i++) begin
      instr(1'b0, 1'b1, 1'b0, 10'(i * 100));
      chk($sformatf("nest%0d.pc", i), 32'(pc), 32'(i * 100));
    end
    chk("nest4.err", 32'(stack_err), 32'd0);
    instr(1'b0, 1'b1, 1'b0, 10'd500);
    chk("nest5.pc", 32'(pc), 32'd500);
    chk("nest5.err", 32'(stack_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      instr(1'b0, 1'b0, 1'b1, 10'd0);
      chk($sformatf("unwind%0d.pc", i), 32'(pc), 32'(ret_pc[i]));
    end
    instr(1'b0, 1'b0, 1'b1, 10'd0);
    chk("underflow.pc", 32'(pc), 32'd8);
    chk("underflow.err", 32'(stack_err), 32'd1);

    // Redirect requests outside stage 10 are ignored
    jump = 1'b1; target = 10'd99; step();
    chk("early_jump.pc", 32'(pc), 32'd8);
    jump = 1'b0; target = 10'd0; step(); step();
    chk("early_jump.pc9", 32'(pc), 32'd9);

    // Test 5: 3-cycle stall in stage 01 freezes stage, pc and flags
    step();
    stall = 1'b1; flag_we = 1'b1; alu_gt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.stage", i), 32'(stage), 32'd1);
      chk($sformatf("stall%0d.pc", i), 32'(pc), 32'd9);
      chk($sformatf("stall%0d.gt", i), 32'(gtQ), 32'd0);
    end
    stall = 1'b0; flag_we = 1'b0; alu_gt = 1'b0;
    step();
    chk("unstall.stage", 32'(stage), 32'd2);
    step();
    chk("unstall.pc", 32'(pc), 32'd10);

    // PC wrap from max to 0
    instr(1'b1, 1'b0, 1'b0, 10'd1023);
    chk("wrap.max", 32'(pc), 32'd1023);
    instr(1'b0, 1'b0, 1'b0, 10'd0);
    chk("wrap.zero", 32'(pc), 32'd0);

    // Test 6: halt with jump, frozen HALT, restart
    step(); step();
    halt_req = 1'b1; jump = 1'b1; target = 10'd12;
    step();
    halt_req = 1'b0; target = 10'd77;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("halt%0d.pc", i), 32'(pc), 32'd12);
      chk($sformatf("halt%0d.done", i), 32'(done), 32'd1);
      chk($sformatf("halt%0d.running", i), 32'(running), 32'd0);
      chk($sformatf("halt%0d.stage", i), 32'(stage), 32'd0);
      step();
    end
    jump = 1'b0; target = 10'd0;
    start = 1'b1; step(); start = 1'b0;
    chk("restart.pc", 32'(pc), 32'd0);
    chk("restart.running", 32'(running), 32'd1);
    chk("restart.done", 32'(done), 32'd0);
    chk("restart.err", 32'(stack_err), 32'd1);
    chk("restart.eq", 32'(equalQ), 32'd1);

    // start while running is ignored
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("rerun.stage", 32'(stage), 32'd2);
    step();
    chk("rerun.pc", 32'(pc), 32'd1);

    // Reset mid-stage 01
    step();
    chk("prereset.stage", 32'(stage), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk_reset_vals("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
